// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures a byte on each
// rising edge of valid_data into a circular buffer and presents it on a FWFT valid/ready port.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              valid_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [7:0]        drop_cnt
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_valid_q;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_wr_req;
    logic w_pop;
    logic w_wr_acc;
    logic w_drop;

    assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_req = valid_data & ~r_valid_q;
    assign w_pop    = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the write.
    assign w_wr_acc = w_wr_req & (~w_full | w_pop);
    assign w_drop   = w_wr_req & w_full & ~w_pop;

    // valid_q resets high so a level already present at reset release is ignored.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            r_valid_q <= 1'b1;
        end else begin
            r_valid_q <= valid_data;
        end
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_acc && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= p_data;
        end
    end

    // A drop in the same cycle as ovf_clr wins: status restarts at one dropped byte.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_valid = ~w_empty;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-level reference model predicts
// stored bytes and status; a negedge monitor checks every presented byte.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic       clk2;
    logic       rst;
    logic [7:0] p_data;
    logic       valid_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         m_count = 0;
    bit         m_prev_valid = 1'b1;
    bit         m_ovf = 1'b0;
    int         m_drop = 0;

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .p_data     (p_data),
        .valid_data (valid_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a new byte arrives on each 0->1 transition of valid_data;
    // it is stored if there is room (or a byte leaves this cycle), else it is counted as dropped.
    always @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_count      = 0;
            m_prev_valid = 1'b1;
            m_ovf        = 1'b0;
            m_drop       = 0;
        end else begin
            bit arrive, leave, dropped;
            arrive       = valid_data && !m_prev_valid;
            m_prev_valid = valid_data;
            leave        = (m_count > 0) && out_ready;
            dropped      = 1'b0;
            if (arrive) begin
                if (m_count < DEPTH || leave) begin
                    exp_q.push_back(p_data);
                    m_count = m_count + 1;
                end else begin
                    dropped = 1'b1;
                    m_ovf   = 1'b1;
                    m_drop  = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
                end
            end
            if (!dropped && ovf_clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (leave) m_count = m_count - 1;
        end
    end

    // Monitor: head byte must match the oldest expected byte; a handshake retires it.
    always @(negedge clk2) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_valid_unexpected: got out_valid=1 data=0x%0h expected no byte at %0t",
                         out_data, $time);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk2) begin
        #1;
        if (rst) begin
            chk("count", count, m_count);
            chk("full", full, m_count == DEPTH);
            chk("empty", empty, m_count == 0);
            chk("out_valid", out_valid, m_count > 0);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic step();
        @(posedge clk2);
        #2;
    endtask

    task automatic pulse(input logic [7:0] b, input int len);
        p_data     = b;
        valid_data = 1'b1;
        repeat (len) step();
        valid_data = 1'b0;
        step();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        p_data     = '0;
        valid_data = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) step();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b1;
        step();

        // Three bytes, then drain in order.
        pulse(8'h41, 1);
        pulse(8'h42, 1);
        pulse(8'h43, 1);
        chk("t1_count", count, 3);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_head", out_data, 8'h41);
        drain(3);
        chk("t1_empty", empty, 1);

        // Held level gives one write.
        pulse(8'h5A, 5);
        chk("t2_count", count, 1);
        drain(1);

        // Overflow by two, drain, clear.
        for (int i = 0; i < 10; i++) pulse(8'(i), 1);
        chk("t3_full", full, 1);
        chk("t3_count", count, 8);
        chk("t3_overflow", overflow, 1);
        chk("t3_drop_cnt", drop_cnt, 2);
        drain(8);
        chk("t3_empty", empty, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared", overflow, 0);
        chk("t3_drop_cleared", drop_cnt, 0);

        // Write coincident with pop while full.
        for (int i = 0; i < 8; i++) pulse(8'h10 + 8'(i), 1);
        chk("t4_full", full, 1);
        p_data     = 8'hAA;
        valid_data = 1'b1;
        out_ready  = 1'b1;
        step();
        valid_data = 1'b0;
        out_ready  = 1'b0;
        step();
        chk("t4_count", count, 8);
        chk("t4_no_overflow", overflow, 0);
        drain(7);
        chk("t4_last_head", out_data, 8'hAA);
        drain(1);
        chk("t4_empty", empty, 1);

        // Drop in the same cycle as ovf_clr.
        for (int i = 0; i < 10; i++) pulse(8'h60 + 8'(i), 1);
        chk("t6_drop_pre", drop_cnt, 2);
        p_data     = 8'hEE;
        valid_data = 1'b1;
        ovf_clr    = 1'b1;
        step();
        ovf_clr    = 1'b0;
        valid_data = 1'b0;
        step();
        chk("t6_overflow", overflow, 1);
        chk("t6_drop_cnt", drop_cnt, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        drain(8);

        // valid_data high across reset release.
        valid_data = 1'b1;
        rst        = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        valid_data = 1'b0;
        step();
        chk("t5_empty", empty, 1);
        chk("t5_count", count, 0);

        // Asynchronous reset with four bytes buffered.
        for (int i = 0; i < 4; i++) pulse(8'hC0 + 8'(i), 1);
        chk("t5_count4", count, 4);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_async_count", count, 0);
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_data", out_data, 0);
        step();
        rst = 1'b1;
        step();

        // Randomised traffic: filling phase then draining phase.
        for (int ph = 0; ph < 2; ph++) begin
            repeat (400) begin
                valid_data = ($urandom % 3) == 0;
                p_data     = 8'($urandom);
                out_ready  = (ph == 0) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
                ovf_clr    = ($urandom % 40) == 0;
                step();
            end
        end
        valid_data = 1'b0;
        ovf_clr    = 1'b0;
        drain(DEPTH + 2);
        chk("final_empty", empty, 1);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
